sound_event_scheduler: RTL and testbench
========================================

SOUND_EVENT_SCHEDULER -- requirements
Module: sound_event_scheduler

Interface
REQ-001 Parameter TONE_CYCLES, default 50_000_000, clock cycles one tone plays (1 s at 50 MHz); SHALL be >=2.
REQ-002 Parameter GAP_CYCLES, default 2_500_000, silent cycles between consecutive tones; SHALL be >=1.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 goal  input  1  request pulse, tone code 10 (220 Hz).
REQ-006 brick  input  1  request pulse, tone code 11 (550 Hz).
REQ-007 paddle  input  1  request pulse, tone code 01 (330 Hz).
REQ-008 wall  input  1  request pulse, tone code 00 (440 Hz).
REQ-009 mute  input  1  level; silences and flushes the scheduler.
REQ-010 tone_en  output  1  registered; high while a tone plays, gates the frequency generators.
REQ-011 tone_sel  output  2  registered tone code of the playing tone.
REQ-012 busy  output  1  registered; high in PLAY or GAP.
REQ-013 pending  output  4  registered {goal,brick,paddle,wall} outstanding requests.
REQ-014 done  output  1  one-cycle pulse on the cycle a tone completes normally.

Function
REQ-015 States SHALL be IDLE, PLAY, GAP; tone_en=1 exactly in PLAY.
REQ-016 A request input high at a rising edge SHALL set its pending bit unless that edge launches it; repeats of an already-pending event SHALL merge.
REQ-017 Priority SHALL be fixed: goal > brick > paddle > wall.
REQ-018 In IDLE, selection SHALL use pending OR current requests; the winner launches at that edge (PLAY, tone_sel loaded, its bit cleared), giving 1-cycle latency from request to tone_en.
REQ-019 PLAY SHALL last exactly TONE_CYCLES cycles, then GAP for exactly GAP_CYCLES cycles, then IDLE for at least one cycle.
REQ-020 done SHALL pulse in the last PLAY cycle of a normally completed tone.
REQ-021 A goal request during PLAY of a non-goal tone SHALL preempt: counter restarts, tone_sel=10, aborted tone discarded (not re-queued), no done pulse.
REQ-022 A goal request during PLAY of a goal tone SHALL set pending[3] only.
REQ-023 A request arriving on the same edge its bit is cleared by launch SHALL not be lost unless it is the launched event itself.
REQ-024 mute=1 at an edge SHALL force IDLE, clear pending, block capture and hold tone_en=0; sequencing resumes on the first edge with mute=0.
REQ-025 Duration counter width SHALL be clog2 of max(TONE_CYCLES,GAP_CYCLES); no wrap occurs within a phase.

Reset
REQ-026 reset=0 at an edge SHALL give IDLE, tone_en=0, tone_sel=00, busy=0, pending=0000, done=0, counter=0, aborting any tone.
REQ-027 Requests coincident with reset SHALL be ignored.

Structure
REQ-028 Tone codes and state encoding SHALL live in shared package sound_pkg, reused by sound_controller.
REQ-029 One sub-module, sound_timer (load, enable, terminal-count pulse), SHALL implement the phase counter.
REQ-030 The block SHALL contain no frequency generation; tone_sel/tone_en drive the existing generators.

Verification (TONE_CYCLES=8, GAP_CYCLES=2)
REQ-031 wall pulse at cycle 0 -> tone_en=1, tone_sel=00 cycles 1-8; done at cycle 8; busy=0 from cycle 11.
REQ-032 paddle and wall together at cycle 0 -> paddle (01) cycles 1-8, gap 9-10, idle 11, wall (00) from cycle 12.
REQ-033 paddle at 0, goal at 4 -> tone_sel=10 from cycle 5 for 8 cycles, no done for paddle, pending=0000 afterwards.
REQ-034 wall pulsed three times during a brick tone -> pending=0001 once, single wall tone follows.
REQ-035 mute asserted mid-PLAY with pending=0110 -> next cycle tone_en=0, busy=0, pending=0000.
REQ-036 reset low at cycle 3 of a tone with goal high -> all outputs reset values next cycle, no goal tone afterwards.

Source files
------------

// File: rtl/sound_pkg.sv
// Purpose: shared tone codes, scheduler state encoding and event-priority helpers.
// Latency: n/a (package only).
// Backpressure: n/a. Reused by sound_event_scheduler and sound_controller.
package sound_pkg;

  // Tone codes understood by the existing frequency generators.
  localparam logic [1:0] TONE_WALL   = 2'b00;  // 440 Hz
  localparam logic [1:0] TONE_PADDLE = 2'b01;  // 330 Hz
  localparam logic [1:0] TONE_GOAL   = 2'b10;  // 220 Hz
  localparam logic [1:0] TONE_BRICK  = 2'b11;  // 550 Hz

  // Scheduler states.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_GAP  = 2'b10;

  // Event vectors are ordered {goal, brick, paddle, wall}; bit 3 has top priority.
  function automatic logic [3:0] highest_event(input logic [3:0] ev);
    logic [3:0] r;
    r = '0;
    if (ev[3])      r = 4'b1000;
    else if (ev[2]) r = 4'b0100;
    else if (ev[1]) r = 4'b0010;
    else if (ev[0]) r = 4'b0001;
    return r;
  endfunction

  function automatic logic [1:0] event_code(input logic [3:0] onehot);
    logic [1:0] c;
    c = TONE_WALL;
    if (onehot[3])      c = TONE_GOAL;
    else if (onehot[2]) c = TONE_BRICK;
    else if (onehot[1]) c = TONE_PADDLE;
    return c;
  endfunction

endpackage

// File: rtl/sound_timer.sv
// Purpose: down-counting phase timer; tc is high while the count sits at zero.
// Latency: load takes effect at the next edge; tc is combinational from the count.
// Backpressure: none. Ports: clk, reset (sync, active-low), load/load_value, enable, tc.
module sound_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Load wins over counting; the count parks at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/sound_event_scheduler.sv
// Purpose: queues game sound events by fixed priority and sequences tone/gap phases.
// Latency: 1 cycle from request to tone_en when idle; goal preempts a playing non-goal tone.
// Backpressure: none; repeated requests merge into one pending bit, mute flushes everything.
// Ports: clk, reset (sync, active-low); goal/brick/paddle/wall request pulses; mute level;
//        tone_en, tone_sel, busy, pending registered; done is a last-PLAY-cycle pulse.
module sound_event_scheduler
  import sound_pkg::*;
#(
  parameter int TONE_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       goal,
  input  logic       brick,
  input  logic       paddle,
  input  logic       wall,
  input  logic       mute,
  output logic       tone_en,
  output logic [1:0] tone_sel,
  output logic       busy,
  output logic [3:0] pending,
  output logic       done
);

  localparam int MAX_CYC = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] TONE_LOAD = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  logic [1:0]       state, state_nxt;
  logic [1:0]       sel_nxt;
  logic [3:0]       pend_nxt;
  logic [3:0]       req, cand, win;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             tc;

  assign req  = {goal, brick, paddle, wall};
  assign cand = pending | req;
  assign win  = highest_event(cand);

  always_comb begin
    state_nxt = state;
    sel_nxt   = tone_sel;
    pend_nxt  = pending | req;
    load      = 1'b0;
    load_val  = '0;
    case (state)
      ST_IDLE: begin
        if (cand != 4'b0000) begin
          state_nxt = ST_PLAY;
          sel_nxt   = event_code(win);
          pend_nxt  = cand & ~win;
          load      = 1'b1;
          load_val  = TONE_LOAD;
        end
      end
      ST_PLAY: begin
        // A goal arriving on the final PLAY edge lets the tone finish (done
        // already shown) and is queued instead; otherwise it restarts as goal.
        if (tc) begin
          state_nxt = ST_GAP;
          load      = 1'b1;
          load_val  = GAP_LOAD;
        end else if (goal && (tone_sel != TONE_GOAL)) begin
          sel_nxt   = TONE_GOAL;
          pend_nxt  = pending | {1'b0, req[2:0]};
          load      = 1'b1;
          load_val  = TONE_LOAD;
        end
      end
      ST_GAP: begin
        if (tc) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (mute) begin
      state_nxt = ST_IDLE;
      pend_nxt  = 4'b0000;
      load      = 1'b1;
      load_val  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      tone_sel <= TONE_WALL;
      pending  <= 4'b0000;
      tone_en  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      tone_sel <= sel_nxt;
      pending  <= pend_nxt;
      tone_en  <= (state_nxt == ST_PLAY);
      busy     <= (state_nxt != ST_IDLE);
    end
  end

  sound_timer #(.WIDTH(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_val),
    .enable     (state != ST_IDLE),
    .tc         (tc)
  );

  assign done = (state == ST_PLAY) && tc;

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Purpose: self-checking bench for sound_event_scheduler (TONE_CYCLES=8, GAP_CYCLES=2).
// Latency: inputs driven on the falling edge, outputs sampled on the next falling edge.
// Backpressure: n/a.
module tb_sound_event_scheduler;

  localparam int T = 8;
  localparam int G = 2;

  logic       clk;
  logic       reset;
  logic       goal, brick, paddle, wall, mute;
  logic       tone_en;
  logic [1:0] tone_sel;
  logic       busy;
  logic [3:0] pending;
  logic       done;

  sound_event_scheduler #(.TONE_CYCLES(T), .GAP_CYCLES(G)) dut (
    .clk      (clk),
    .reset    (reset),
    .goal     (goal),
    .brick    (brick),
    .paddle   (paddle),
    .wall     (wall),
    .mute     (mute),
    .tone_en  (tone_en),
    .tone_sel (tone_sel),
    .busy     (busy),
    .pending  (pending),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Behavioural model: phase 0 idle, 1 play, 2 gap; elapsed = cycles spent in
  // the current phase including the present one.
  int       m_phase   = 0;
  int       m_elapsed = 0;
  int       m_sel     = 0;
  bit [3:0] m_pend    = 4'b0000;

  function automatic int code_for(input int ev);
    case (ev)
      3:       return 2;
      2:       return 3;
      1:       return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit g, input bit b, input bit p,
                            input bit w, input bit m);
    bit [3:0] rq;
    bit [3:0] c;
    int       pick;
    rq = {g, b, p, w};
    if (!r) begin
      m_phase = 0; m_elapsed = 0; m_sel = 0; m_pend = 4'b0000;
    end else if (m) begin
      m_phase = 0; m_elapsed = 1; m_pend = 4'b0000;
    end else if (m_phase == 0) begin
      c = m_pend | rq;
      pick = -1;
      for (int i = 3; i >= 0; i--) if (pick < 0 && c[i]) pick = i;
      if (pick >= 0) begin
        c[pick] = 1'b0;
        m_pend = c; m_phase = 1; m_elapsed = 1; m_sel = code_for(pick);
      end else begin
        m_elapsed++;
      end
    end else if (m_phase == 1) begin
      if (m_elapsed == T) begin
        m_pend |= rq; m_phase = 2; m_elapsed = 1;
      end else if (g && m_sel != 2) begin
        rq[3] = 1'b0;
        m_pend |= rq; m_sel = 2; m_elapsed = 1;
      end else begin
        m_pend |= rq; m_elapsed++;
      end
    end else begin
      m_pend |= rq;
      if (m_elapsed == G) begin m_phase = 0; m_elapsed = 1; end
      else m_elapsed++;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_compare();
    chk("model tone_en", int'(tone_en), (m_phase == 1) ? 1 : 0);
    chk("model busy", int'(busy), (m_phase != 0) ? 1 : 0);
    chk("model pending", int'(pending), int'(m_pend));
    chk("model done", int'(done), (m_phase == 1 && m_elapsed == T) ? 1 : 0);
    if (m_phase == 1) chk("model tone_sel", int'(tone_sel), m_sel);
  endtask

  // Apply one set of inputs across one rising edge and check against the model.
  task automatic step(input bit r, input bit g, input bit b, input bit p,
                      input bit w, input bit m);
    reset = r; goal = g; brick = b; paddle = p; wall = w; mute = m;
    @(posedge clk);
    model_step(r, g, b, p, w, m);
    @(negedge clk);
    cyc++;
    model_compare();
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("reset tone_en", int'(tone_en), 0);
    chk("reset tone_sel", int'(tone_sel), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset pending", int'(pending), 0);
    chk("reset done", int'(done), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit g, b, p, w;
    bit en;
    int sel;
    bit bsy;
    int pend;
    bit dn;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit g, input bit b, input bit p, input bit w,
                         input bit en, input int sel, input bit bsy,
                         input int pend, input bit dn);
    vec_t v;
    v.g = g; v.b = b; v.p = p; v.w = w;
    v.en = en; v.sel = sel; v.bsy = bsy; v.pend = pend; v.dn = dn;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b0; goal = 0; brick = 0; paddle = 0; wall = 0; mute = 0;

    // Single wall tone, then paddle+wall together (paddle first, wall after idle).
    add_vec(0,0,0,1, 1,0,1,0,0);
    for (int i = 0; i < 6; i++) add_vec(0,0,0,0, 1,0,1,0,0);
    add_vec(0,0,0,0, 1,0,1,0,1);
    add_vec(0,0,0,0, 0,0,1,0,0);
    add_vec(0,0,0,0, 0,0,1,0,0);
    add_vec(0,0,0,0, 0,0,0,0,0);
    add_vec(0,0,1,1, 1,1,1,1,0);
    for (int i = 0; i < 6; i++) add_vec(0,0,0,0, 1,1,1,1,0);
    add_vec(0,0,0,0, 1,1,1,1,1);
    add_vec(0,0,0,0, 0,1,1,1,0);
    add_vec(0,0,0,0, 0,1,1,1,0);
    add_vec(0,0,0,0, 0,1,0,1,0);
    add_vec(0,0,0,0, 1,0,1,0,0);

    do_reset();
    foreach (vecs[i]) begin
      step(1, vecs[i].g, vecs[i].b, vecs[i].p, vecs[i].w, 0);
      chk($sformatf("vec%0d tone_en", i), int'(tone_en), int'(vecs[i].en));
      if (vecs[i].en) chk($sformatf("vec%0d tone_sel", i), int'(tone_sel), vecs[i].sel);
      chk($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].bsy));
      chk($sformatf("vec%0d pending", i), int'(pending), vecs[i].pend);
      chk($sformatf("vec%0d done", i), int'(done), int'(vecs[i].dn));
    end

    // Goal preempts a paddle tone at cycle 4.
    do_reset();
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0);
      chk("preempt paddle done", int'(done), 0);
    end
    step(1, 1, 0, 0, 0, 0);
    chk("preempt sel", int'(tone_sel), 2);
    chk("preempt en", int'(tone_en), 1);
    chk("preempt pend", int'(pending), 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 0, 0);
      chk("preempt early done", int'(done), 0);
    end
    step(1, 0, 0, 0, 0, 0);
    chk("goal done", int'(done), 1);
    idle(3);
    chk("preempt after busy", int'(busy), 0);
    chk("preempt after pend", int'(pending), 0);

    // Three wall pulses during a brick tone merge into one pending wall.
    do_reset();
    step(1, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0);
    end
    chk("merge pend", int'(pending), 1);
    chk("merge sel", int'(tone_sel), 3);
    idle(4);
    chk("merge idle busy", int'(busy), 0);
    step(1, 0, 0, 0, 0, 0);
    chk("merge wall en", int'(tone_en), 1);
    chk("merge wall sel", int'(tone_sel), 0);
    chk("merge wall pend", int'(pending), 0);
    idle(10);
    chk("merge end busy", int'(busy), 0);
    step(1, 0, 0, 0, 0, 0);
    chk("merge single tone", int'(tone_en), 0);

    // Mute mid-PLAY with brick and paddle pending; a request on the mute edge is dropped.
    do_reset();
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 1, 1, 0, 0);
    chk("mute pre pend", int'(pending), 6);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 1);
    chk("mute en", int'(tone_en), 0);
    chk("mute busy", int'(busy), 0);
    chk("mute pend", int'(pending), 0);
    step(1, 0, 0, 0, 0, 0);
    chk("mute resume en", int'(tone_en), 0);

    // Reset during a tone with goal high.
    do_reset();
    step(1, 0, 0, 0, 1, 0);
    idle(2);
    step(0, 1, 0, 0, 0, 0);
    chk("rst mid en", int'(tone_en), 0);
    chk("rst mid sel", int'(tone_sel), 0);
    chk("rst mid busy", int'(busy), 0);
    chk("rst mid pend", int'(pending), 0);
    chk("rst mid done", int'(done), 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0, 0);
      chk("rst no goal", int'(tone_en), 0);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 499) != 0),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 79) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
